// File: rtl/pkt_pack_fifo.sv
// Byte-stream to wide-word packer with sop/eop framing checks, feeding an
// internal register-array FIFO drained under downstream b_rdy flow control.
module pkt_pack_fifo #(
    parameter int unsigned DIN_W      = 8,
    parameter int unsigned RATIO      = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned MTY_W     = (RATIO > 2) ? $clog2(RATIO) : 1,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIN_W-1:0]       din,
    input  logic                   din_vld,
    input  logic                   din_sop,
    input  logic                   din_eop,
    output logic                   din_rdy,
    output logic [DIN_W*RATIO-1:0] dout,
    output logic                   dout_vld,
    output logic                   dout_sop,
    output logic                   dout_eop,
    output logic [MTY_W-1:0]       dout_mty,
    input  logic                   b_rdy,
    output logic                   sop_err
);

    localparam int unsigned DOUT_W = DIN_W * RATIO;
    localparam int unsigned LANE_W = MTY_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W  = DOUT_W + 2 + MTY_W;

    logic [LANE_W-1:0] r_lane;
    logic [DOUT_W-1:0] r_acc;
    logic              r_acc_sop;
    logic              r_in_pkt;
    logic [DOUT_W-1:0] r_word;
    logic              r_word_sop;
    logic              r_word_eop;
    logic [MTY_W-1:0]  r_word_mty;
    logic              r_word_vld;

    logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W-1:0]  w_occ;
    logic              w_acc;
    logic              w_take;
    logic              w_done;
    logic [LANE_W-1:0] w_lane;
    logic [DOUT_W-1:0] w_data;
    logic [MTY_W-1:0]  w_mty;
    logic              w_wr;
    logic              w_rd;
    logic [ENT_W-1:0]  w_entry;
    logic [ENT_W-1:0]  w_head;

    // Conservative back-pressure: a word still in the pack register is counted as occupancy.
    assign w_occ   = r_count + CNT_W'(r_word_vld);
    assign din_rdy = (w_occ < CNT_W'(FIFO_DEPTH));

    assign w_acc  = din_vld & din_rdy;
    assign w_take = w_acc & (din_sop | r_in_pkt);
    assign w_lane = din_sop ? '0 : r_lane;
    assign w_done = din_eop | (w_lane == LANE_W'(RATIO - 1));
    assign w_mty  = din_eop ? (MTY_W'(RATIO - 1) - w_lane) : '0;

    // A sop beat discards any partial lanes, so it builds on a cleared word.
    always_comb begin
        w_data = din_sop ? '0 : r_acc;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (w_lane == LANE_W'(i)) begin
                w_data[i*DIN_W +: DIN_W] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane     <= '0;
            r_acc      <= '0;
            r_acc_sop  <= 1'b0;
            r_in_pkt   <= 1'b0;
            r_word     <= '0;
            r_word_sop <= 1'b0;
            r_word_eop <= 1'b0;
            r_word_mty <= '0;
            r_word_vld <= 1'b0;
            sop_err    <= 1'b0;
        end else begin
            r_word_vld <= 1'b0;
            sop_err    <= w_acc & (din_sop ? r_in_pkt : ~r_in_pkt);
            if (w_acc) begin
                if (din_sop && !din_eop) begin
                    r_in_pkt <= 1'b1;
                end else if (din_eop) begin
                    r_in_pkt <= 1'b0;
                end
            end
            if (w_take) begin
                if (w_done) begin
                    r_word     <= w_data;
                    r_word_sop <= din_sop | r_acc_sop;
                    r_word_eop <= din_eop;
                    r_word_mty <= w_mty;
                    r_word_vld <= 1'b1;
                    r_lane     <= '0;
                    r_acc      <= '0;
                    r_acc_sop  <= 1'b0;
                end else begin
                    r_acc      <= w_data;
                    r_lane     <= w_lane + LANE_W'(1);
                    r_acc_sop  <= din_sop | r_acc_sop;
                end
            end
        end
    end

    assign w_wr    = r_word_vld;
    assign w_rd    = (r_count != '0) & b_rdy;
    assign w_entry = {r_word_sop, r_word_eop, r_word_mty, r_word};
    assign w_head  = r_mem[r_rd_ptr];

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_mty <= '0;
        end else begin
            dout_vld <= w_rd;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_mty <= '0;
            if (w_rd) begin
                dout     <= w_head[DOUT_W-1:0];
                dout_sop <= w_head[ENT_W-1];
                dout_eop <= w_head[ENT_W-2];
                dout_mty <= w_head[DOUT_W +: MTY_W];
            end
        end
    end

endmodule

// File: tb/tb_pkt_pack_fifo.sv
// Scoreboard bench for pkt_pack_fifo: a byte-queue packet model predicts words,
// a negedge monitor pops and compares every word the DUT presents.
module tb_pkt_pack_fifo;

    localparam int unsigned DIN_W  = 8;
    localparam int unsigned RATIO  = 2;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned MTY_W  = 1;
    localparam int unsigned DOUT_W = DIN_W * RATIO;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIN_W-1:0]  din = '0;
    logic              din_vld = 1'b0;
    logic              din_sop = 1'b0;
    logic              din_eop = 1'b0;
    logic              din_rdy;
    logic [DOUT_W-1:0] dout;
    logic              dout_vld;
    logic              dout_sop;
    logic              dout_eop;
    logic [MTY_W-1:0]  dout_mty;
    logic              b_rdy = 1'b1;
    logic              sop_err;

    pkt_pack_fifo #(.DIN_W(DIN_W), .RATIO(RATIO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .din_rdy(din_rdy), .dout(dout), .dout_vld(dout_vld),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_mty(dout_mty),
        .b_rdy(b_rdy), .sop_err(sop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DOUT_W-1:0] data;
        bit                sop;
        bit                eop;
        int                mty;
        int                cyc;
    } word_t;

    word_t      exp_q[$];
    word_t      obs_q[$];
    logic [7:0] pend[$];
    bit         m_in_pkt = 1'b0;
    bit         m_first  = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         exp_err_tot = 0;
    int         obs_err_tot = 0;
    int         last_acc_cyc = 0;
    bit         rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: bytes of the current packet gather in a queue; a word is emitted
    // when RATIO bytes are held or the packet ends.
    function automatic void model_accept(input logic [7:0] d, input bit s, input bit e, output bit err);
        word_t w;
        bit    take;
        err  = s ? m_in_pkt : !m_in_pkt;
        take = s || m_in_pkt;
        if (s) begin
            pend.delete();
            m_first = 1'b1;
        end
        if (take) begin
            pend.push_back(d);
            if (pend.size() == int'(RATIO) || e) begin
                w.data = '0;
                foreach (pend[i]) w.data[i*8 +: 8] = pend[i];
                w.sop = m_first;
                w.eop = e;
                w.mty = e ? int'(RATIO) - pend.size() : 0;
                w.cyc = 0;
                exp_q.push_back(w);
                pend.delete();
                m_first = 1'b0;
            end
        end
        if (s && !e) m_in_pkt = 1'b1;
        else if (e) m_in_pkt = 1'b0;
        if (err) exp_err_tot++;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (sop_err) obs_err_tot++;
            if (dout_vld) begin
                word_t o;
                word_t x;
                o.data = dout; o.sop = dout_sop; o.eop = dout_eop;
                o.mty = int'(dout_mty); o.cyc = cyc;
                obs_q.push_back(o);
                check("word_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    check("dout", 64'(dout), 64'(x.data));
                    check("dout_sop", 64'(dout_sop), 64'(x.sop));
                    check("dout_eop", 64'(dout_eop), 64'(x.eop));
                    check("dout_mty", 64'(dout_mty), 64'(x.mty));
                end
            end else begin
                check("idle_flags", 64'({dout_sop, dout_eop, dout_mty}), 64'(0));
            end
        end
    end

    // Called at a negedge; holds the beat until accepted, then checks sop_err.
    task automatic send_beat(input logic [7:0] d, input bit s, input bit e);
        int g;
        bit err;
        din = d; din_sop = s; din_eop = e; din_vld = 1'b1;
        g = 0;
        while (!din_rdy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            check("din_rdy_timeout", 64'(din_rdy), 64'(1));
            din_vld = 1'b0;
            return;
        end
        model_accept(d, s, e, err);
        @(negedge clk);
        din_vld = 1'b0;
        last_acc_cyc = cyc;
        check("sop_err", 64'(sop_err), 64'(err));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_word(input int idx, input logic [15:0] d, input bit s, input bit e, input int m);
        if (idx < obs_q.size()) begin
            check("dir_data", 64'(obs_q[idx].data), 64'(d));
            check("dir_sop", 64'(obs_q[idx].sop), 64'(s));
            check("dir_eop", 64'(obs_q[idx].eop), 64'(e));
            check("dir_mty", 64'(obs_q[idx].mty), 64'(m));
        end else begin
            check("dir_word_count", 64'(obs_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int         a;
        int         e0;
        int         nb;
        logic [7:0] v;
        bit         half;
        bit         err;

        repeat (3) @(negedge clk);
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_dout_vld", 64'(dout_vld), 64'(0));
        check("rst_dout_sop", 64'(dout_sop), 64'(0));
        check("rst_dout_eop", 64'(dout_eop), 64'(0));
        check("rst_dout_mty", 64'(dout_mty), 64'(0));
        check("rst_sop_err", 64'(sop_err), 64'(0));
        check("rst_din_rdy", 64'(din_rdy), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Four-byte packet and first-word latency
        obs_q.delete();
        send_beat(8'h11, 1, 0);
        send_beat(8'h22, 0, 0);
        a = last_acc_cyc;
        send_beat(8'h33, 0, 0);
        send_beat(8'h44, 0, 1);
        drain();
        check("t1_words", 64'(obs_q.size()), 64'(2));
        chk_word(0, 16'h2211, 1, 0, 0);
        chk_word(1, 16'h4433, 0, 1, 0);
        if (obs_q.size() > 0) check("t1_latency", 64'(obs_q[0].cyc - a), 64'(2));

        // Odd-length packet leaves an empty high lane
        obs_q.delete();
        send_beat(8'hAA, 1, 0);
        send_beat(8'hBB, 0, 0);
        send_beat(8'hCC, 0, 1);
        drain();
        check("t2_words", 64'(obs_q.size()), 64'(2));
        chk_word(0, 16'hBBAA, 1, 0, 0);
        chk_word(1, 16'h00CC, 0, 1, 1);

        // Single-beat packet
        obs_q.delete();
        e0 = obs_err_tot;
        send_beat(8'h5A, 1, 1);
        drain();
        check("t3_words", 64'(obs_q.size()), 64'(1));
        chk_word(0, 16'h005A, 1, 1, 1);
        check("t3_no_err", 64'(obs_err_tot - e0), 64'(0));

        // Repeated sop discards the partial word
        obs_q.delete();
        e0 = obs_err_tot;
        send_beat(8'h01, 1, 0);
        send_beat(8'h02, 1, 0);
        send_beat(8'h03, 0, 1);
        drain();
        check("t5_words", 64'(obs_q.size()), 64'(1));
        chk_word(0, 16'h0302, 1, 1, 0);
        check("t5_err_pulses", 64'(obs_err_tot - e0), 64'(1));

        // Back-pressure: count beats accepted before din_rdy drops
        obs_q.delete();
        b_rdy = 1'b0;
        @(negedge clk);
        nb = 0; v = 8'h40; half = 1'b0;
        while (din_rdy && nb < 200) begin
            din = v; din_sop = !half; din_eop = half; din_vld = 1'b1;
            model_accept(v, !half, half, err);
            @(negedge clk);
            nb++; v++; half = !half;
        end
        check("bp_beats_before_stall", 64'(nb), 64'(2 * DEPTH));
        din = v; din_sop = 1'b1; din_eop = 1'b0; din_vld = 1'b1;
        repeat (8) @(negedge clk);
        check("bp_rdy_held_low", 64'(din_rdy), 64'(0));
        din_vld = 1'b0;
        check("bp_no_output", 64'(obs_q.size()), 64'(0));
        b_rdy = 1'b1;
        drain();
        check("bp_drained_words", 64'(obs_q.size()), 64'(DEPTH));
        check("bp_rdy_back", 64'(din_rdy), 64'(1));

        // Reset mid-packet loses the partial word
        obs_q.delete();
        send_beat(8'h77, 1, 0);
        rst_n = 1'b0;
        exp_q.delete(); pend.delete(); m_in_pkt = 1'b0; m_first = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_din_rdy", 64'(din_rdy), 64'(1));
        rst_n = 1'b1;
        e0 = obs_err_tot;
        @(negedge clk);
        send_beat(8'h81, 1, 0);
        send_beat(8'h82, 0, 1);
        drain();
        check("t6_words", 64'(obs_q.size()), 64'(1));
        chk_word(0, 16'h8281, 1, 1, 0);
        check("t6_err_pulses", 64'(obs_err_tot - e0), 64'(0));

        // Random packets with occasional framing faults and random b_rdy
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    int len;
                    int fault;
                    len   = int'($urandom_range(1, 7));
                    fault = int'($urandom_range(0, 11));
                    for (int i = 0; i < len; i++) begin
                        bit s;
                        s = (i == 0) ? (fault != 0) : (fault == 1 && i == 1);
                        send_beat(8'($urandom), s, i == len - 1);
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    b_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        b_rdy = 1'b1;
        drain();
        check("err_total", 64'(obs_err_tot), 64'(exp_err_tot));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_pack_fifo.md
# pkt_pack_fifo

Packet width-up converter with an integrated, parametrised buffer. It packs a narrow sop/eop-framed byte stream into words RATIO lanes wide and stores each word with its sop, eop and empty-lane count in an internal register-array FIFO. The FIFO drains to a downstream consumer under `b_rdy` flow control. It sits between the byte-oriented receive path and the wide packet-processing datapath, and adds upstream back-pressure (`din_rdy`) and malformed-framing detection.

## Interface
- `DIN_W`, 8: input lane width in bits.
- `RATIO`, 2: lanes per output word, ≥2. The output width is `DIN_W*RATIO`.
- `FIFO_DEPTH`, 16: word entries, a power of 2, ≥4.
- Localparam `MTY_W` = max(1, clog2(RATIO)).
- Localparam `CNT_W` = clog2(FIFO_DEPTH)+1.

- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in DIN_W: input lane.
- `din_vld` in 1: input beat valid.
- `din_sop` in 1: first beat of a packet; only meaningful when `din_vld`=1.
- `din_eop` in 1: last beat of a packet; only meaningful when `din_vld`=1.
- `din_rdy` out 1: the block can accept a beat.
- `dout` out DIN_W*RATIO: packed word; lane 0 = `dout[DIN_W-1:0]` holds the earliest byte.
- `dout_vld` out 1: output word valid.
- `dout_sop` out 1: word carries the packet start.
- `dout_eop` out 1: word carries the packet end.
- `dout_mty` out MTY_W: count of empty (high) lanes in an eop word.
- `b_rdy` in 1: downstream can take a word this cycle.
- `sop_err` out 1: one-cycle pulse when framing is malformed.

## Operation
- Accept rule: a beat is accepted when `din_vld` && `din_rdy`. Beats offered while `din_rdy`=0 are ignored and produce no state change.
- Lane counter `lane` runs 0..RATIO-1. On each accepted beat, `din` is written into lane `lane`.
- A word completes when an accepted beat has `lane`==RATIO-1 or has `din_eop`=1. On completion, `lane` returns to 0.
- On completion, the pack register is loaded with:
  - the data, with unfilled lanes forced to 0;
  - sop = 1 if this word contains the packet's sop beat;
  - eop = `din_eop`;
  - mty = RATIO-1-`lane` if eop, else 0.
- `word_vld` pulses for one cycle; `wrreq` = `word_vld`.
- Packet state `in_pkt`:
  - set by an accepted sop beat without eop;
  - cleared by an accepted eop beat.
- `sop_err` pulses in the cycle after the accepted beat in either case:
  - sop while `in_pkt`=1: the partial lanes are discarded, and the sop beat restarts at lane 0 as a new packet;
  - a beat with no sop while `in_pkt`=0: the beat is dropped.
- FIFO: memory is `DIN_W*RATIO+2+MTY_W` bits wide, with write and read pointers and an occupancy `count` (CNT_W).
  - Simultaneous write and read leaves `count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Back-pressure: `din_rdy` = (`count` + `word_vld`) < FIFO_DEPTH, computed combinationally from registers. Reads are ignored in this calculation, so it is conservative. The FIFO is therefore never written when full.
- Read rule: `rdreq` = !empty && `b_rdy`.
  - On a read, `dout` and the flags are registered from the head entry and `dout_vld`=1.
  - Without a read, `dout_vld`, `dout_sop`, `dout_eop` and `dout_mty` are 0. `dout` holds its last value.

## Timing
- Reset values:
  - `dout`=0, `dout_vld`=0, `dout_sop`=0, `dout_eop`=0, `dout_mty`=0, `sop_err`=0.
  - `din_rdy`=1 (since `count`=0).
  - Internal `lane`=0, `in_pkt`=0, `word_vld`=0, pointers=0.
- Latency, with `b_rdy` held at 1:
  - edge 0: the completing beat is sampled;
  - edge 1: FIFO write;
  - edge 2: `dout_vld`=1.
  - Total: 2 cycles after the completing beat.
- Throughput: one word per cycle in and out at RATIO beats per word on the input side. The FIFO never underflows or overflows.
- Full: `count`==FIFO_DEPTH is reachable only through the `din_rdy` rule. `din_rdy` falls as soon as (`count`+`word_vld`) reaches FIFO_DEPTH, and it rises in the cycle after a read lowers `count`.
- Empty: `rdreq` is forced to 0 regardless of `b_rdy`.
- Reset mid-packet: all state is cleared immediately (asynchronous). The partial word and all FIFO contents are lost. No output pulse is generated on release.

## Test plan
- RATIO=2: packet bytes 0x11,0x22,0x33,0x44 (sop on the first beat, eop on the last) -> two words:
  - 0x2211 with sop=1, eop=0, mty=0;
  - 0x4433 with sop=0, eop=1, mty=0;
  - first `dout_vld` 2 cycles after beat 2.
- RATIO=2: 3-byte packet 0xAA,0xBB,0xCC -> 0xBBAA with sop=1, then 0x00CC with eop=1, mty=1.
- Single beat 0x5A with sop=eop=1 -> one word 0x005A with sop=1, eop=1, mty=1. No `sop_err`.
- `b_rdy`=0 with continuous 2-byte packets -> `din_rdy` drops after 16 words are committed (15 in the FIFO plus 1 in the pack register). Raising `b_rdy` drains 16 words in order, with none lost or duplicated.
- sop,0x01 then sop,0x02 then eop,0x03 -> `sop_err` pulses once; a single word 0x0302 with sop=1, eop=1; byte 0x01 is absent.
- Reset asserted after 1 byte of a packet, then released and a clean 2-byte packet sent -> only the clean packet appears at the output. Exactly 0 `sop_err` pulses.
